// File: rtl/ldl_rr_pkg.sv
// Shared types and helpers for the weighted round-robin burst scheduler.
package ldl_rr_pkg;

  typedef enum logic {RR_IDLE, RR_BURST} rr_state_e;

  // Modulo-n increment of a requester index.
  function automatic int unsigned rr_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ldl_rr_ffs.sv
// Rotated find-first-set: first set bit of i_elig at or above i_start, wrapping to 0.
module ldl_rr_ffs
  import ldl_rr_pkg::*;
#(
  parameter int BIN_WIDTH = 3,
  parameter int REQ_WIDTH = 1 << BIN_WIDTH
) (
  input  logic [REQ_WIDTH-1:0] i_elig,
  input  logic [BIN_WIDTH-1:0] i_start,
  output logic                 o_found,
  output logic [BIN_WIDTH-1:0] o_sel
);

  logic [BIN_WIDTH-1:0] w_idx;

  // Scan from the far end down so the closest hit to i_start is written last.
  // Index wrap relies on REQ_WIDTH being exactly 2**BIN_WIDTH.
  always_comb begin
    o_found = 1'b0;
    o_sel   = '0;
    w_idx   = '0;
    for (int k = REQ_WIDTH - 1; k >= 0; k--) begin
      w_idx = i_start + BIN_WIDTH'(k);
      if (i_elig[w_idx]) begin
        o_found = 1'b1;
        o_sel   = w_idx;
      end
    end
  end

endmodule

// File: rtl/ldl_rr_wrr_sched.sv
// Weighted round-robin burst scheduler sharing one valid/ready sink among REQ_WIDTH requesters.
module ldl_rr_wrr_sched
  import ldl_rr_pkg::*;
#(
  parameter int BIN_WIDTH  = 3,
  parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
  parameter int WGT_WIDTH  = 4,
  parameter int USER_WIDTH = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [REQ_WIDTH-1:0]            req,
  input  logic [REQ_WIDTH*USER_WIDTH-1:0] iuser,
  input  logic                            ready,
  input  logic                            cfg_we,
  input  logic [BIN_WIDTH-1:0]            cfg_idx,
  input  logic [WGT_WIDTH-1:0]            cfg_wgt,
  output logic [REQ_WIDTH-1:0]            ack,
  output logic [BIN_WIDTH-1:0]            bin,
  output logic                            valid,
  output logic [USER_WIDTH-1:0]           ouser,
  output logic                            busy,
  output logic [WGT_WIDTH-1:0]            credit
);

  rr_state_e            r_state;
  logic [BIN_WIDTH-1:0] r_ptr;
  logic [BIN_WIDTH-1:0] r_owner;
  logic [WGT_WIDTH-1:0] r_credit;
  logic [WGT_WIDTH-1:0] r_wgt [REQ_WIDTH];

  logic [REQ_WIDTH-1:0] w_elig;
  logic [BIN_WIDTH-1:0] w_next;
  logic [BIN_WIDTH-1:0] w_start;
  logic [BIN_WIDTH-1:0] w_sel;
  logic                 w_found;
  logic                 w_xfer;
  logic                 w_end;

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      w_elig[i] = req[i] & (r_wgt[i] != '0);
    end
  end

  // One search engine: IDLE starts at ptr, a burst end starts just past the owner.
  assign w_next  = BIN_WIDTH'(rr_inc(int'(r_owner), REQ_WIDTH));
  assign w_start = (r_state == RR_BURST) ? w_next : r_ptr;

  ldl_rr_ffs #(
    .BIN_WIDTH(BIN_WIDTH),
    .REQ_WIDTH(REQ_WIDTH)
  ) u_ffs (
    .i_elig (w_elig),
    .i_start(w_start),
    .o_found(w_found),
    .o_sel  (w_sel)
  );

  assign valid  = (r_state == RR_BURST) & req[r_owner];
  assign w_xfer = valid & ready;
  assign w_end  = (r_state == RR_BURST) & (~req[r_owner] | (w_xfer & (r_credit == WGT_WIDTH'(1))));

  always_comb begin
    ack          = '0;
    ack[r_owner] = w_xfer;
  end

  assign bin    = r_owner;
  assign ouser  = valid ? iuser[int'(r_owner)*USER_WIDTH +: USER_WIDTH] : '0;
  assign busy   = (r_state == RR_BURST);
  assign credit = r_credit;

  // Credit is latched from the pre-write weight, so same-cycle cfg writes never alter a start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RR_IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_credit <= '0;
      for (int i = 0; i < REQ_WIDTH; i++) begin
        r_wgt[i] <= WGT_WIDTH'(1);
      end
    end else begin
      if (cfg_we) begin
        r_wgt[cfg_idx] <= cfg_wgt;
      end
      case (r_state)
        RR_IDLE: begin
          if (w_found) begin
            r_owner  <= w_sel;
            r_credit <= r_wgt[w_sel];
            r_state  <= RR_BURST;
          end
        end
        RR_BURST: begin
          if (w_end) begin
            r_ptr <= w_next;
            if (w_found) begin
              r_owner  <= w_sel;
              r_credit <= r_wgt[w_sel];
            end else begin
              r_credit <= '0;
              r_state  <= RR_IDLE;
            end
          end else if (w_xfer && r_credit != '0) begin
            r_credit <= r_credit - WGT_WIDTH'(1);
          end
        end
        default: r_state <= RR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ldl_rr_wrr_sched.sv
// Directed bench for ldl_rr_wrr_sched with an ack scoreboard of expected (bin, credit) beats.
module tb_ldl_rr_wrr_sched;

  localparam int BW = 2;
  localparam int RW = 4;
  localparam int WW = 4;
  localparam int UW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [RW-1:0]  req;
  logic [RW*UW-1:0] iuser;
  logic           ready;
  logic           cfg_we;
  logic [BW-1:0]  cfg_idx;
  logic [WW-1:0]  cfg_wgt;
  logic [RW-1:0]  ack;
  logic [BW-1:0]  bin;
  logic           valid;
  logic [UW-1:0]  ouser;
  logic           busy;
  logic [WW-1:0]  credit;

  always #5 clk = ~clk;

  ldl_rr_wrr_sched #(
    .BIN_WIDTH (BW),
    .WGT_WIDTH (WW),
    .USER_WIDTH(UW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .iuser  (iuser),
    .ready  (ready),
    .cfg_we (cfg_we),
    .cfg_idx(cfg_idx),
    .cfg_wgt(cfg_wgt),
    .ack    (ack),
    .bin    (bin),
    .valid  (valid),
    .ouser  (ouser),
    .busy   (busy),
    .credit (credit)
  );

  typedef struct packed {
    logic [BW-1:0] bin;
    logic [WW-1:0] credit;
  } beat_t;

  beat_t sbq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic push(input int b, input int c);
    beat_t e;
    e.bin    = BW'(b);
    e.credit = WW'(c);
    sbq.push_back(e);
  endtask

  // One clock: score any ack at the falling edge, then step past the rising edge.
  task automatic tick();
    beat_t e;
    logic [RW-1:0] one_hot;
    @(negedge clk);
    if (ack !== '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_ack", 32'(ack), 32'(0));
      end else begin
        e = sbq.pop_front();
        one_hot = RW'(1) << e.bin;
        chk("beat_bin", 32'(bin), 32'(e.bin));
        chk("beat_credit", 32'(credit), 32'(e.credit));
        chk("beat_ouser", 32'(ouser), 32'(e.bin));
        chk("beat_ack", 32'(ack), 32'(one_hot));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int idx, input int w);
    cfg_we  = 1'b1;
    cfg_idx = BW'(idx);
    cfg_wgt = WW'(w);
    tick();
    cfg_we  = 1'b0;
  endtask

  // Withdraw all requests, let the burst close, and confirm every expected beat arrived.
  task automatic drain(input string tag);
    req = '0;
    ticks(2);
    chk(tag, 32'(sbq.size()), 32'(0));
    chk({tag, "_idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    rst     = 1'b1;
    req     = '0;
    iuser   = {2'd3, 2'd2, 2'd1, 2'd0};
    ready   = 1'b1;
    cfg_we  = 1'b0;
    cfg_idx = '0;
    cfg_wgt = '0;
    @(posedge clk);
    #1;
    tick();

    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_bin", 32'(bin), 32'(0));
    chk("rst_ouser", 32'(ouser), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_credit", 32'(credit), 32'(0));
    rst = 1'b0;

    // 1: unit weights rotate 0,1,2,3,0; valid waits one cycle after req.
    req = 4'b1111;
    #1;
    chk("t1_valid_latency", 32'(valid), 32'(0));
    for (int i = 0; i < 5; i++) push(i % 4, 1);
    ticks(6);
    drain("t1_drain");

    // 2: weight 3 vs 1.
    do_reset();
    cfg_write(0, 3);
    req = 4'b0011;
    for (int r = 0; r < 2; r++) begin
      push(0, 3); push(0, 2); push(0, 1); push(1, 1);
    end
    ticks(9);
    drain("t2_drain");

    // 3: sole requester re-wins with no bubble.
    do_reset();
    cfg_write(0, 2);
    req = 4'b0001;
    push(0, 2); push(0, 1); push(0, 2); push(0, 1);
    ticks(5);
    chk("t3_nobubble", 32'(sbq.size()), 32'(0));
    chk("t3_valid", 32'(valid), 32'(1));
    drain("t3_drain");

    // 4: owner 2 withdraws after one beat; owner 3 takes over on the same edge.
    do_reset();
    cfg_write(2, 3);
    req = 4'b1100;
    push(2, 3);
    ticks(2);
    req = 4'b1000;
    #1;
    chk("t4_withdraw_ack", 32'(ack), 32'(0));
    chk("t4_withdraw_valid", 32'(valid), 32'(0));
    tick();
    chk("t4_next_bin", 32'(bin), 32'(3));
    chk("t4_next_valid", 32'(valid), 32'(1));
    push(3, 1);
    tick();
    drain("t4_drain");

    // 5: ready low holds owner and credit.
    do_reset();
    cfg_write(0, 4);
    req = 4'b0001;
    push(0, 4); push(0, 3);
    ticks(3);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_credit", 32'(credit), 32'(2));
      chk("t5_hold_bin", 32'(bin), 32'(0));
      chk("t5_hold_ack", 32'(ack), 32'(0));
    end
    ready = 1'b1;
    push(0, 2); push(0, 1);
    ticks(2);
    drain("t5_drain");

    // 6: masking the running owner lets its burst finish, then skips it.
    do_reset();
    cfg_write(1, 2);
    req = 4'b0011;
    push(0, 1);
    ticks(2);
    chk("t6_owner1", 32'(bin), 32'(1));
    cfg_we  = 1'b1;
    cfg_idx = 2'd1;
    cfg_wgt = '0;
    push(1, 2);
    tick();
    cfg_we = 1'b0;
    push(1, 1); push(0, 1); push(0, 1);
    ticks(3);
    drain("t6_drain");

    // 7: reset mid-burst aborts and restores unit weights.
    do_reset();
    cfg_write(0, 3);
    req = 4'b0001;
    push(0, 3);
    ticks(2);
    chk("t7_busy_before", 32'(busy), 32'(1));
    rst   = 1'b1;
    ready = 1'b0;
    tick();
    chk("t7_valid_after_rst", 32'(valid), 32'(0));
    chk("t7_busy_after_rst", 32'(busy), 32'(0));
    chk("t7_credit_after_rst", 32'(credit), 32'(0));
    rst   = 1'b0;
    ready = 1'b1;
    req   = 4'b1111;
    push(0, 1); push(1, 1);
    ticks(3);
    drain("t7_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
